arb_ram: RTL and testbench

//   Parametrised single-clock RAM shared by two requesters (A, B) through a

---
 rtl/arb_ram.sv | 106 ++++++++++
 tb/tb_arb_ram.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/arb_ram.sv
// Byte-masked RAM shared by ports A and B through a round-robin arbiter.
// Read data returns RD_LAT cycles after the accept edge; the losing requester holds until granted.
module arb_ram #(
    parameter int BYTE_W   = 8,
    parameter int LANES    = 2,
    parameter int ADDR_W   = 8,
    parameter int NUM_ADDR = 1 << ADDR_W,
    parameter int RD_LAT   = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      a_req,
    output logic                      a_gnt,
    input  logic                      a_we,
    input  logic [LANES-1:0]          a_be,
    input  logic [ADDR_W-1:0]         a_addr,
    input  logic [BYTE_W*LANES-1:0]   a_wdata,
    output logic                      a_rvalid,
    output logic [BYTE_W*LANES-1:0]   a_rdata,
    input  logic                      b_req,
    output logic                      b_gnt,
    input  logic                      b_we,
    input  logic [LANES-1:0]          b_be,
    input  logic [ADDR_W-1:0]         b_addr,
    input  logic [BYTE_W*LANES-1:0]   b_wdata,
    output logic                      b_rvalid,
    output logic [BYTE_W*LANES-1:0]   b_rdata
);

    localparam int W     = BYTE_W * LANES;
    localparam int IDX_W = (NUM_ADDR > 1) ? $clog2(NUM_ADDR) : 1;
    localparam logic [ADDR_W:0] ADDR_LIMIT = (ADDR_W + 1)'(NUM_ADDR);

    logic              prio_b;
    logic              acc;
    logic              acc_we;
    logic [LANES-1:0]  acc_be;
    logic [ADDR_W-1:0] acc_addr;
    logic [W-1:0]      acc_wdata;
    logic              in_range;
    logic [IDX_W-1:0]  idx;
    logic [W-1:0]      rd_word;

    logic [W-1:0]      mem [NUM_ADDR];

    logic [RD_LAT-1:0] pvld;
    logic [RD_LAT-1:0] ptag;
    logic [W-1:0]      pdat [RD_LAT];

    // Grants are suppressed during reset so nothing is accepted on a reset edge.
    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (rst_n) begin
            if (a_req && (!b_req || !prio_b)) a_gnt = 1'b1;
            else if (b_req)                   b_gnt = 1'b1;
        end
    end

    assign acc       = a_gnt | b_gnt;
    assign acc_we    = b_gnt ? b_we    : a_we;
    assign acc_be    = b_gnt ? b_be    : a_be;
    assign acc_addr  = b_gnt ? b_addr  : a_addr;
    assign acc_wdata = b_gnt ? b_wdata : a_wdata;
    assign in_range  = {1'b0, acc_addr} < ADDR_LIMIT;
    assign idx       = acc_addr[IDX_W-1:0];
    assign rd_word   = in_range ? mem[idx] : '0;

    always_ff @(posedge clk) begin
        if (!rst_n)     prio_b <= 1'b0;
        else if (a_gnt) prio_b <= 1'b1;
        else if (b_gnt) prio_b <= 1'b0;
    end

    // Storage has no reset; contents survive rst_n.
    always_ff @(posedge clk) begin
        if (acc && acc_we && in_range) begin
            for (int i = 0; i < LANES; i++) begin
                if (acc_be[i]) mem[idx][i*BYTE_W +: BYTE_W] <= acc_wdata[i*BYTE_W +: BYTE_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pvld <= '0;
            ptag <= '0;
            for (int i = 0; i < RD_LAT; i++) pdat[i] <= '0;
        end else begin
            pvld[0] <= acc && !acc_we;
            ptag[0] <= b_gnt;
            pdat[0] <= rd_word;
            for (int i = 1; i < RD_LAT; i++) begin
                pvld[i] <= pvld[i-1];
                ptag[i] <= ptag[i-1];
                pdat[i] <= pdat[i-1];
            end
        end
    end

    assign a_rvalid = pvld[RD_LAT-1] && !ptag[RD_LAT-1];
    assign b_rvalid = pvld[RD_LAT-1] &&  ptag[RD_LAT-1];
    assign a_rdata  = a_rvalid ? pdat[RD_LAT-1] : '0;
    assign b_rdata  = b_rvalid ? pdat[RD_LAT-1] : '0;

endmodule

// File: tb/tb_arb_ram.sv
// Bench for arb_ram: table of single-port accesses, arbitration and reset sequences,
// with a read-return scoreboard checked every cycle.
module tb_arb_ram;

    localparam int BYTE_W   = 8;
    localparam int LANES    = 2;
    localparam int ADDR_W   = 8;
    localparam int NUM_ADDR = 200;
    localparam int RD_LAT   = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
    logic [1:0]  a_be = '0, b_be = '0;
    logic [7:0]  a_addr = '0, b_addr = '0;
    logic [15:0] a_wdata = '0, b_wdata = '0;
    logic        a_gnt, b_gnt, a_rvalid, b_rvalid;
    logic [15:0] a_rdata, b_rdata;

    arb_ram #(.BYTE_W(BYTE_W), .LANES(LANES), .ADDR_W(ADDR_W),
              .NUM_ADDR(NUM_ADDR), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_gnt(a_gnt), .a_we(a_we), .a_be(a_be), .a_addr(a_addr),
        .a_wdata(a_wdata), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_gnt(b_gnt), .b_we(b_we), .b_be(b_be), .b_addr(b_addr),
        .b_wdata(b_wdata), .b_rvalid(b_rvalid), .b_rdata(b_rdata)
    );

    always #5 clk = ~clk;

    typedef struct { bit port; logic [15:0] data; int due; } rd_t;
    typedef struct {
        bit port; bit we; logic [1:0] be; logic [7:0] addr; logic [15:0] wdata; logic [15:0] exp;
    } vec_t;

    rd_t  sb[$];
    vec_t tbl[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    logic [15:0] arb_d [4] = '{16'h3000, 16'h3111, 16'h3222, 16'h3333};

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Every cycle: outputs must match the scoreboard head if due now, else be idle.
    always @(negedge clk) begin
        rd_t e;
        bit ea_v, eb_v;
        logic [15:0] ea_d, eb_d;
        cyc++;
        if (mon_en) begin
            ea_v = 1'b0; eb_v = 1'b0; ea_d = '0; eb_d = '0;
            if (sb.size() > 0 && sb[0].due == cyc) begin
                e = sb.pop_front();
                if (e.port) begin eb_v = 1'b1; eb_d = e.data; end
                else        begin ea_v = 1'b1; ea_d = e.data; end
            end
            check("a_rvalid", a_rvalid, ea_v);
            check("a_rdata",  a_rdata,  ea_d);
            check("b_rvalid", b_rvalid, eb_v);
            check("b_rdata",  b_rdata,  eb_d);
            if (!rst_n) begin
                check("a_gnt_in_reset", a_gnt, 0);
                check("b_gnt_in_reset", b_gnt, 0);
            end
        end
    end

    // Single-requester access; expected to be granted on the first cycle.
    task automatic access(bit p, bit we, logic [1:0] be, logic [7:0] addr,
                          logic [15:0] wd, logic [15:0] exp, bit push);
        int n = 0;
        bit g = 1'b0;
        if (p) begin b_req = 1'b1; b_we = we; b_be = be; b_addr = addr; b_wdata = wd; end
        else   begin a_req = 1'b1; a_we = we; a_be = be; a_addr = addr; a_wdata = wd; end
        do begin
            @(negedge clk);
            g = p ? b_gnt : a_gnt;
            n++;
        end while (!g && n < 20);
        check("single_req_grant_cycles", n, 1);
        @(posedge clk);
        if (g && !we && push) sb.push_back('{p, exp, cyc + RD_LAT});
        #1;
        if (p) b_req = 1'b0; else a_req = 1'b0;
    endtask

    // Both ports request reads of 0x30.. from reset; grants must alternate starting with A.
    task automatic arb_run(int steps);
        a_req = 1'b1; a_we = 1'b0; a_addr = 8'h30;
        b_req = 1'b1; b_we = 1'b0; b_addr = 8'h31;
        for (int i = 0; i < steps; i++) begin
            @(negedge clk);
            check("arb_a_gnt", a_gnt, (i % 2) == 0);
            check("arb_b_gnt", b_gnt, (i % 2) == 1);
            @(posedge clk);
            sb.push_back('{(i % 2) == 1, arb_d[i], cyc + RD_LAT});
            #1;
            if (i % 2 == 0) begin
                if (i + 2 < steps) a_addr = 8'(8'h30 + i + 2); else a_req = 1'b0;
            end else begin
                if (i + 2 < steps) b_addr = 8'(8'h30 + i + 2); else b_req = 1'b0;
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() > 0 && n < 20) begin @(negedge clk); n++; end
        check("scoreboard_drained", sb.size(), 0);
        @(posedge clk); #1;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    initial begin
        int seen;
        tbl.push_back('{0, 1, 2'b11, 8'h10, 16'hBEEF, 16'h0000});
        tbl.push_back('{1, 0, 2'b00, 8'h10, 16'h0000, 16'hBEEF});
        tbl.push_back('{0, 1, 2'b01, 8'h10, 16'h1234, 16'h0000});
        tbl.push_back('{0, 0, 2'b00, 8'h10, 16'h0000, 16'hBE34});
        tbl.push_back('{1, 1, 2'b10, 8'h10, 16'h5600, 16'h0000});
        tbl.push_back('{1, 0, 2'b00, 8'h10, 16'h0000, 16'h5634});
        tbl.push_back('{0, 1, 2'b11, 8'h05, 16'h00AA, 16'h0000});
        tbl.push_back('{0, 0, 2'b00, 8'h05, 16'h0000, 16'h00AA});
        tbl.push_back('{1, 1, 2'b11, 8'h20, 16'h1111, 16'h0000});
        tbl.push_back('{1, 1, 2'b00, 8'h20, 16'hFFFF, 16'h0000});
        tbl.push_back('{0, 0, 2'b00, 8'h20, 16'h0000, 16'h1111});
        tbl.push_back('{0, 1, 2'b11, 8'd250, 16'h7777, 16'h0000});
        tbl.push_back('{1, 0, 2'b00, 8'd250, 16'h0000, 16'h0000});
        tbl.push_back('{0, 1, 2'b11, 8'd199, 16'hC0DE, 16'h0000});
        tbl.push_back('{1, 0, 2'b00, 8'd199, 16'h0000, 16'hC0DE});
        tbl.push_back('{0, 1, 2'b11, 8'h30, 16'h3000, 16'h0000});
        tbl.push_back('{1, 1, 2'b11, 8'h31, 16'h3111, 16'h0000});
        tbl.push_back('{0, 1, 2'b11, 8'h32, 16'h3222, 16'h0000});
        tbl.push_back('{1, 1, 2'b11, 8'h33, 16'h3333, 16'h0000});
        tbl.push_back('{0, 0, 2'b00, 8'h31, 16'h0000, 16'h3111});
        tbl.push_back('{1, 0, 2'b00, 8'h30, 16'h0000, 16'h3000});

        // Reset with both ports requesting.
        a_req = 1'b1; b_req = 1'b1;
        @(posedge clk); mon_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_a_gnt", a_gnt, 0);
            check("rst_b_gnt", b_gnt, 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; a_req = 1'b0; b_req = 1'b0;

        foreach (tbl[i])
            access(tbl[i].port, tbl[i].we, tbl[i].be, tbl[i].addr, tbl[i].wdata, tbl[i].exp, 1'b1);
        drain();

        // Memory persists through reset; arbitration restarts with A.
        pulse_reset();
        arb_run(4);
        drain();

        // A read in flight is dropped by a reset on the following edge.
        access(1'b0, 1'b0, 2'b00, 8'h10, 16'h0000, 16'h0000, 1'b0);
        rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            seen += int'(a_rvalid | b_rvalid);
        end
        check("flushed_read_no_rvalid", seen, 0);
        @(posedge clk); #1;

        // That grant went to A, yet reset must hand priority back to A.
        arb_run(2);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
